// File: rtl/btn_event_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_event_ctrl: per-channel debounce plus a press / auto-repeat event port |
// | Auto-repeat logic is built only when BTN_AUTOREPEAT_EN is defined.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module btn_event_ctrl #(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    localparam int ID_W           = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] level_out,
    output logic                event_valid_out,
    output logic [ID_W-1:0]     event_id_out,
    output logic                event_repeat_out,
    input  logic                event_ready_in,
    output logic [NUM_BTNS-1:0] drop_out
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NUM_BTNS-1:0] r_sync1, r_sync2, r_level, r_level_d;
    logic [DB_W-1:0]     r_db_cnt [NUM_BTNS];
    logic [NUM_BTNS-1:0] r_pend, r_pend_rep, r_drop;
    logic                r_valid, r_rep;
    logic [ID_W-1:0]     r_id;

    logic [NUM_BTNS-1:0] w_rise, w_fire, w_set, w_clr, w_drop;
    logic [ID_W-1:0]     w_sel;
    logic                w_any, w_load;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_level_d <= '0;
            for (int i = 0; i < NUM_BTNS; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1   <= btn_in;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (r_sync2[i] != r_level[i]) begin
                    // The count that would reach DEBOUNCE_CYCLES flips the level instead.
                    if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_db_cnt[i] <= '0;
                        r_level[i]  <= ~r_level[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_rise = r_level & ~r_level_d;

    generate
        for (genvar g = 0; g < NUM_BTNS; g++) begin : g_rpt
`ifdef BTN_AUTOREPEAT_EN
            localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RPT_W   = $clog2(RPT_MAX + 1);
            localparam logic [1:0] S_IDLE   = 2'd0;
            localparam logic [1:0] S_HOLD   = 2'd1;
            localparam logic [1:0] S_REPEAT = 2'd2;

            logic [1:0]       r_state, w_next;
            logic [RPT_W-1:0] r_rcnt;
            logic             w_fire_ch;

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_state <= S_IDLE;
                    r_rcnt  <= '0;
                end else begin
                    r_state <= w_next;
                    if (w_next == S_IDLE || w_next != r_state || w_fire_ch)
                        r_rcnt <= '0;
                    else
                        r_rcnt <= r_rcnt + 1'b1;
                end
            end

            always_comb begin
                w_next = r_state;
                case (r_state)
                    S_IDLE:   if (w_rise[g]) w_next = S_HOLD;
                    S_HOLD:   if (!r_level[g]) w_next = S_IDLE;
                              else if (w_fire_ch) w_next = S_REPEAT;
                    S_REPEAT: if (!r_level[g]) w_next = S_IDLE;
                    default:  w_next = S_IDLE;
                endcase
            end

            // Gated by the level so a release never yields a trailing repeat.
            always_comb begin
                w_fire_ch = 1'b0;
                if (r_level[g]) begin
                    if (r_state == S_HOLD && r_rcnt == RPT_W'(REPEAT_DELAY - 1))
                        w_fire_ch = 1'b1;
                    else if (r_state == S_REPEAT && r_rcnt == RPT_W'(REPEAT_PERIOD - 1))
                        w_fire_ch = 1'b1;
                end
            end

            assign w_fire[g] = w_fire_ch;
`else
            assign w_fire[g] = 1'b0;
`endif
        end
    endgenerate

    assign w_set  = w_rise | w_fire;
    assign w_any  = |r_pend;
    assign w_load = ~r_valid | event_ready_in;

    always_comb begin
        w_sel = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (r_pend[i]) w_sel = ID_W'(i);
        end
    end

    always_comb begin
        w_clr = '0;
        if (w_load && w_any) w_clr[w_sel] = 1'b1;
    end

    // A set landing on a bit being cleared this cycle is a fresh entry, not a coalesce.
    assign w_drop = w_set & r_pend & ~w_clr;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pend     <= '0;
            r_pend_rep <= '0;
            r_drop     <= '0;
            r_valid    <= 1'b0;
            r_id       <= '0;
            r_rep      <= 1'b0;
        end else begin
            r_pend     <= (r_pend & ~w_clr) | w_set;
            r_pend_rep <= (r_pend_rep & ~w_set) | w_fire;
            r_drop     <= w_drop;
            if (w_load) begin
                r_valid <= w_any;
                if (w_any) begin
                    r_id  <= w_sel;
                    r_rep <= r_pend_rep[w_sel];
                end
            end
        end
    end

    assign level_out        = r_level;
    assign event_valid_out  = r_valid;
    assign event_id_out     = r_id;
    assign event_repeat_out = r_rep;
    assign drop_out         = r_drop;

endmodule
`default_nettype wire

// File: doc/btn_event_ctrl.md
BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 Parameter NUM_BTNS, default 4: number of button channels, legal range 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required before a level change is accepted, minimum 2.
REQ-003 Parameter REPEAT_DELAY, default 50_000_000: cycles from a press event to the first auto-repeat event.
REQ-004 Parameter REPEAT_PERIOD, default 10_000_000: cycles between subsequent auto-repeat events.
REQ-005 Derived width ID_W SHALL be max(1, clog2(NUM_BTNS)).
REQ-006 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-007 rst_n_in  input  1  asynchronous, active-low reset.
REQ-008 btn_in  input  NUM_BTNS  raw asynchronous button levels, 1 = pressed.
REQ-009 level_out  output  NUM_BTNS  debounced button levels.
REQ-010 event_valid_out  output  1  event available.
REQ-011 event_id_out  output  ID_W  channel index of the presented event.
REQ-012 event_repeat_out  output  1  1 = auto-repeat event, 0 = initial press.
REQ-013 event_ready_in  input  1  consumer accepts the event when high with event_valid_out.
REQ-014 drop_out  output  NUM_BTNS  one-cycle pulse per channel when an event is coalesced.

Function
REQ-015 Each btn_in bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-016 Per channel, a counter SHALL count cycles in which the synchronised level differs from level_out, and clear whenever they are equal.
REQ-017 level_out SHALL toggle on the cycle the counter reaches DEBOUNCE_CYCLES, giving DEBOUNCE_CYCLES+2 cycles from a clean btn_in edge to level_out change.
REQ-018 A level_out 0->1 transition SHALL set that channel's pending bit on the next cycle with the repeat flag cleared.
REQ-019 The per-channel repeat FSM SHALL have states IDLE, HOLD and REPEAT: IDLE->HOLD on level_out rise; HOLD->REPEAT after REPEAT_DELAY cycles; REPEAT re-arms every REPEAT_PERIOD cycles; any state->IDLE on level_out fall.
REQ-020 Each HOLD->REPEAT transition and each REPEAT period expiry SHALL set the pending bit with the repeat flag set.
REQ-021 If the pending bit is already set when a new event arrives for that channel, the events SHALL coalesce (repeat flag takes the newer value) and drop_out for that channel SHALL pulse for one cycle.
REQ-022 When event_valid_out is 0, or event_valid_out and event_ready_in are both 1, the lowest-index pending channel SHALL be loaded into the output register and its pending bit cleared; event_valid_out is high the following cycle.
REQ-023 Rising level_out to event_valid_out latency SHALL be 2 cycles when the output register is free.
REQ-024 While event_valid_out=1 and event_ready_in=0, event_id_out and event_repeat_out SHALL hold stable.
REQ-025 event_valid_out SHALL deassert after a handshake only if no channel is pending; back-to-back events at one per cycle SHALL be sustained.
REQ-026 A clear and a new set on the same channel in the same cycle SHALL leave the pending bit set, with no drop.
REQ-027 Simultaneous press events on several channels SHALL be presented in ascending index order, one per handshake, with none lost.
REQ-028 Release events SHALL NOT generate events.

Reset
REQ-029 While rst_n_in=0: level_out=0, event_valid_out=0, event_id_out=0, event_repeat_out=0, drop_out=0; all counters, pending bits and synchronisers 0; all FSMs IDLE.
REQ-030 Reset asserted mid-operation SHALL discard any presented or pending event immediately; the rst_n_in deassertion edge is synchronised upstream.
REQ-031 A button held through reset SHALL produce exactly one press event DEBOUNCE_CYCLES+4 cycles after rst_n_in rises.

Configuration
REQ-032 Macro BTN_AUTOREPEAT_EN defined: the repeat FSMs and counters of REQ-019/020 are present.
REQ-033 Macro BTN_AUTOREPEAT_EN undefined: no repeat logic is built, event_repeat_out is constant 0, and only press events are generated.

Verification (NUM_BTNS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, ready tied 1 unless stated)
REQ-034 btn_in[2] clean rise -> level_out[2]=1 after 6 cycles; single event id=2, repeat=0 at cycle 8.
REQ-035 btn_in[1] bouncing every 2 cycles for 30 cycles, then stable 1 -> no level change during the bounce; exactly one event id=1.
REQ-036 btn_in[3] and btn_in[0] rise in the same cycle with event_ready_in held 0 for 10 cycles -> id=0 held stable; after ready goes high, id=0 then id=3 on consecutive cycles.
REQ-037 With BTN_AUTOREPEAT_EN defined, btn_in[0] held for 60 cycles -> press event, then repeat=1 events 20, 28, 36, 44 and 52 cycles after the press; nothing after release. With the macro undefined, only the press event is produced.
REQ-038 With ready held 0 while channel 1 repeats twice -> drop_out[1] pulses once; one coalesced event, repeat=1, is delivered on ready.
REQ-039 rst_n_in pulsed low while event_valid_out=1 -> all outputs are 0 in the same cycle; if btn_in is still high, one fresh event arrives 8 cycles after release.
